// File: rtl/frame_capture_ctrl.sv
// Capture sequencer between the camera byte stream and the DMA sink: arms on command,
// aligns to start-of-frame, counts bytes/lines and marks line/frame ends with m_tlast.
module frame_capture_ctrl #(
    parameter int LINE_BYTES     = 1280,
    parameter int LINES          = 480,
    parameter int TLAST_PER_LINE = 0,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             start,
    input  logic             stop,
    input  logic             continuous,
    input  logic             sof,
    input  logic [7:0]       s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [7:0]       m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_count,
    output logic             err_short,
    output logic             err_stall,
    output logic [1:0]       o_dbg_state
);

    // Handshake: a byte moves on either side only in a cycle where valid && ready are
    // both high; the output register holds data/last stable while m_tvalid && !m_tready.

    localparam int BYTE_W = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
    localparam int LINE_W = (LINES > 1) ? $clog2(LINES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_STREAM   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [7:0]         r_m_tdata;
    logic               r_m_tvalid;
    logic               r_m_tlast;
    logic               r_final;
    logic [BYTE_W-1:0]  r_byte_cnt;
    logic [LINE_W-1:0]  r_line_cnt;
    logic [CNT_W-1:0]   r_frame_count;
    logic               r_err_short;
    logic               r_err_stall;
    logic               r_stop_pending;
    logic               r_cont;

    logic               w_in_stream;
    logic               w_out_free;
    logic               w_s_tready;
    logic               w_accept;
    logic               w_line_end;
    logic               w_last_line;
    logic               w_mid_frame;
    logic               w_sof_short;
    logic               w_load;
    logic               w_frame_end;
    logic               w_stop_req;
    logic               w_arm;

    assign w_in_stream = (r_state == ST_STREAM);
    assign w_out_free  = !r_m_tvalid || m_tready;
    // Outside STREAM the upstream is always drained so the pixel FIFO never backs up.
    assign w_s_tready  = w_in_stream ? w_out_free : 1'b1;
    assign w_accept    = s_tvalid && w_s_tready;
    assign w_line_end  = (r_byte_cnt == BYTE_W'(LINE_BYTES - 1));
    assign w_last_line = (r_line_cnt == LINE_W'(LINES - 1));
    assign w_mid_frame = (r_byte_cnt != '0) || (r_line_cnt != '0);
    assign w_sof_short = w_in_stream && sof && w_mid_frame;
    assign w_load      = w_in_stream && w_accept && !w_sof_short;
    assign w_frame_end = w_load && w_line_end && w_last_line;
    assign w_stop_req  = r_stop_pending || stop;
    assign w_arm       = (r_state == ST_IDLE) && start && !stop;

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_arm) begin
                    w_next_state = ST_WAIT_SOF;
                end
            end
            ST_WAIT_SOF: begin
                if (stop) begin
                    w_next_state = ST_IDLE;
                end else if (sof) begin
                    w_next_state = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (w_frame_end) begin
                    w_next_state = (r_cont && !w_stop_req) ? ST_WAIT_SOF : ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_m_tdata      <= '0;
            r_m_tvalid     <= 1'b0;
            r_m_tlast      <= 1'b0;
            r_final        <= 1'b0;
            r_byte_cnt     <= '0;
            r_line_cnt     <= '0;
            r_frame_count  <= '0;
            r_err_short    <= 1'b0;
            r_err_stall    <= 1'b0;
            r_stop_pending <= 1'b0;
            r_cont         <= 1'b0;
        end else begin
            // The output register drains in every state; leaving STREAM never drops it.
            if (r_m_tvalid && m_tready) begin
                r_m_tvalid <= 1'b0;
            end
            if (w_load) begin
                r_m_tdata  <= s_tdata;
                r_m_tvalid <= 1'b1;
                r_m_tlast  <= w_line_end && ((TLAST_PER_LINE != 0) || w_last_line);
                r_final    <= w_line_end && w_last_line;
            end
            if (sof && r_m_tvalid && !m_tready) begin
                r_err_stall <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_arm) begin
                        r_err_short    <= 1'b0;
                        r_err_stall    <= 1'b0;
                        r_frame_count  <= '0;
                        r_byte_cnt     <= '0;
                        r_line_cnt     <= '0;
                        r_stop_pending <= 1'b0;
                        r_cont         <= continuous;
                    end
                end
                ST_WAIT_SOF: begin
                    if (stop) begin
                        r_stop_pending <= 1'b0;
                    end else if (sof) begin
                        r_byte_cnt <= '0;
                        r_line_cnt <= '0;
                    end
                end
                ST_STREAM: begin
                    // A mid-frame sof restarts counting; the truncated frame is never closed.
                    if (w_sof_short) begin
                        r_byte_cnt  <= '0;
                        r_line_cnt  <= '0;
                        r_err_short <= 1'b1;
                    end else if (w_load) begin
                        if (w_line_end) begin
                            r_byte_cnt <= '0;
                            r_line_cnt <= w_last_line ? '0 : r_line_cnt + LINE_W'(1);
                        end else begin
                            r_byte_cnt <= r_byte_cnt + BYTE_W'(1);
                        end
                    end
                    if (w_frame_end) begin
                        r_frame_count  <= r_frame_count + CNT_W'(1);
                        r_stop_pending <= 1'b0;
                        r_cont         <= continuous;
                    end else if (stop) begin
                        r_stop_pending <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_tready    = w_s_tready;
    assign m_tdata     = r_m_tdata;
    assign m_tvalid    = r_m_tvalid;
    assign m_tlast     = r_m_tlast;
    assign busy        = (r_state != ST_IDLE) || r_m_tvalid;
    assign frame_done  = r_m_tvalid && m_tready && r_final;
    assign frame_count = r_frame_count;
    assign err_short   = r_err_short;
    assign err_stall   = r_err_stall;
    assign o_dbg_state = r_state;

endmodule
